// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX buffer.
//   Define UART_TX_FIFO_EN for a 4-entry FIFO; otherwise the buffer is a single holding register.
//   Ports: clk (rising edge), reset (async, active-high),
//          a/wd/we (processor data bus), rd (combinational read data),
//          hit (address falls in this 8-byte window), txd (registered serial out, idle high).
//   Map: BASE+0 TXDATA (write pushes wd[7:0], reads 0);
//        BASE+4 STATUS {count[7:4], overflow[3], empty[2], full[1], busy[0]}; a write clears overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic        hit,
  output logic        txd
);
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    sh_q;
  logic          txd_q;
  logic [7:0]    mem_q [2**PW];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push_req, clr, full, empty, bit_end, pop, push, busy;
  logic [7:0]    head;
  logic          unused_bits;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign hit         = a[31:3] == BASE_ADDR[31:3];
  assign push_req    = we & hit & ~a[2];
  assign clr         = we & hit & a[2];
  assign full        = count_q == 3'(DEPTH);
  assign empty       = count_q == 3'd0;
  assign bit_end     = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign busy        = state_q != IDLE;
  // The FSM pops from IDLE, or at the last STOP cycle so frames run back to back.
  assign pop         = ~empty & (state_q == IDLE | (state_q == STOP & bit_end));
  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign push        = push_req & (~full | pop);
  assign head        = mem_q[rp_q];
  assign txd         = txd_q;
  assign rd          = (hit & a[2]) ? {24'b0, 1'b0, count_q, ovf_q, empty, full, busy} : 32'b0;
  assign unused_bits = ^{wd[31:8], a[1:0]};
  always_comb begin
    wp_d    = push ? inc(wp_q) : wp_q;
    rp_d    = pop ? inc(rp_q) : rp_q;
    count_d = count_q + 3'(push) - 3'(pop);
    ovf_d   = clr ? 1'b0 : (push_req & ~push) ? 1'b1 : ovf_q;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= wd[7:0];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE:
          if (pop) begin
            sh_q    <= head;
            cnt_q   <= '0;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        START: begin
          cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
          if (bit_end) begin
            txd_q   <= sh_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
              sh_q  <= sh_q >> 1;
              txd_q <= sh_q[1];
            end
          end
        end
        STOP: begin
          cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
          if (bit_end) begin
            if (pop) begin
              sh_q    <= head;
              txd_q   <= 1'b0;
              state_q <= START;
            end else state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench; written bytes are expected on txd as 8N1 frames.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int CPB = 4;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  typedef struct {
    logic [7:0] d;
    bit         ok;
    int         st;
  } rx_t;
  logic clk = 0, reset = 1, we = 0;
  logic [31:0] a = BASE + 4, wd = 0, rd;
  logic hit, txd;
  int vectors = 0, miscompares = 0, cyc = 0, low_cnt = 0, last_wcyc = 0;
  logic [7:0] exp_q [$];
  rx_t rx_q [$];
  bit in_f = 0, mok = 0;
  int k = 0, mst = 0;
  logic [7:0] md = 0;
  logic refv = 0;
  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we), .rd(rd), .hit(hit), .txd(txd)
  );
  always #5 clk = ~clk;
  // Serial receiver: samples txd at each falling edge and records whole frames.
  always @(negedge clk) begin
    cyc++;
    if (reset) in_f = 0;
    else begin
      if (txd !== 1'b1) low_cnt++;
      if (!in_f && txd === 1'b0) begin
        in_f = 1; k = 0; mok = 1; mst = cyc; md = '0;
      end
      if (in_f) begin
        if (k / CPB == 0) begin
          if (txd !== 1'b0) mok = 0;
        end else if (k / CPB == 9) begin
          if (txd !== 1'b1) mok = 0;
        end else if (k % CPB == 0) begin
          md[k / CPB - 1] = txd;
          refv = txd;
        end else if (txd !== refv) mok = 0;
        k++;
        if (k == 10 * CPB) begin
          rx_q.push_back('{md, mok, mst});
          in_f = 0;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    a = addr; wd = data; we = 1;
    tick();
    we = 0;
    last_wcyc = cyc;
  endtask
  task automatic wait_rx(input int n, output bit to);
    int i = 0;
    while (rx_q.size() < n && i < 2000) begin
      tick();
      i++;
    end
    to = rx_q.size() < n;
  endtask
  task automatic test_reset();
    tick(); tick();
    vectors++;
    if (txd !== 1'b1) begin $display("FAIL reset_txd_held: got %b want 1", txd); miscompares++; end
    reset = 0;
    a = BASE + 4; #1;
    vectors++;
    if (rd !== 32'h4) begin $display("FAIL reset_status: got %h want 00000004", rd); miscompares++; end
    vectors++;
    if (hit !== 1'b1) begin $display("FAIL reset_hit: got %b want 1", hit); miscompares++; end
    vectors++;
    if (txd !== 1'b1) begin $display("FAIL reset_txd: got %b want 1", txd); miscompares++; end
    a = BASE; #1;
    vectors++;
    if (rd !== 32'h0) begin $display("FAIL txdata_read: got %h want 00000000", rd); miscompares++; end
    tick();
  endtask
  task automatic test_single();
    int bc = 0;
    bit to;
    rx_t r;
    logic [7:0] e;
    wr(BASE, 32'hDEAD_BEA5);
    exp_q.push_back(8'hA5);
    a = BASE + 4;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd[0] === 1'b1) bc++;
      else if (bc > 0) break;
    end
    vectors++;
    if (bc != 10 * CPB) begin $display("FAIL single_busy_cycles: got %0d want %0d", bc, 10 * CPB); miscompares++; end
    wait_rx(1, to);
    vectors++;
    if (to) begin $display("FAIL single_frame_timeout: got 0 frames want 1"); miscompares++; end
    else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (r.d !== e) begin $display("FAIL single_data: got %h want %h", r.d, e); miscompares++; end
      vectors++;
      if (!r.ok) begin $display("FAIL single_framing: got bad frame want good frame"); miscompares++; end
      vectors++;
      if (r.st != last_wcyc + 2) begin $display("FAIL single_start_latency: got %0d want %0d", r.st - last_wcyc, 2); miscompares++; end
    end
    #1;
    vectors++;
    if (rd !== 32'h4) begin $display("FAIL single_status_after: got %h want 00000004", rd); miscompares++; end
  endtask
  task automatic test_patterns();
    logic [7:0] pats [4] = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    bit to;
    rx_t r;
    logic [7:0] e;
    for (int p = 0; p < 4; p++) begin
      wr(BASE, {24'h0, pats[p]});
      exp_q.push_back(pats[p]);
      wait_rx(1, to);
      vectors++;
      if (to) begin $display("FAIL pattern_timeout: got 0 frames want 1 for %h", pats[p]); miscompares++; end
      else begin
        r = rx_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (r.d !== e || !r.ok) begin $display("FAIL pattern_data: got %h ok=%0d want %h ok=1", r.d, r.ok, e); miscompares++; end
      end
    end
    for (int i = 0; i < 10; i++) tick();
  endtask
  task automatic test_back_to_back();
    int first_w = 0, prev_st = 0;
    bit to;
    rx_t r;
    logic [7:0] e, b;
    logic [31:0] st_exp;
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'h10 + 8'(i * 17);
      wr(BASE, {24'h0, b});
      if (i == 0) first_w = last_wcyc;
      if (i < DEPTH + 1) exp_q.push_back(b);
    end
    a = BASE + 4; #1;
    st_exp = (32'(DEPTH) << 4) | 32'h8 | 32'h2 | 32'h1;
    vectors++;
    if (rd !== st_exp) begin $display("FAIL overflow_status: got %h want %h", rd, st_exp); miscompares++; end
    wr(BASE + 4, 32'hFFFF_FFFF);
    a = BASE + 4; #1;
    st_exp = (32'(DEPTH) << 4) | 32'h2 | 32'h1;
    vectors++;
    if (rd !== st_exp) begin $display("FAIL overflow_clear: got %h want %h", rd, st_exp); miscompares++; end
    wait_rx(DEPTH + 1, to);
    vectors++;
    if (to) begin $display("FAIL b2b_timeout: got %0d frames want %0d", rx_q.size(), DEPTH + 1); miscompares++; end
    for (int i = 0; i < DEPTH + 1 && rx_q.size() > 0; i++) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      vectors++;
      if (r.d !== e || !r.ok) begin $display("FAIL b2b_data[%0d]: got %h ok=%0d want %h ok=1", i, r.d, r.ok, e); miscompares++; end
      vectors++;
      if (i == 0 && r.st != first_w + 2) begin $display("FAIL b2b_first_start: got %0d want %0d", r.st - first_w, 2); miscompares++; end
      else if (i > 0 && r.st - prev_st != 10 * CPB) begin $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, r.st - prev_st, 10 * CPB); miscompares++; end
      prev_st = r.st;
    end
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (rd !== 32'h4) begin $display("FAIL b2b_status_after: got %h want 00000004", rd); miscompares++; end
    exp_q.delete();
  endtask
  task automatic test_miss();
    int lc;
    a = BASE + 8; #1;
    vectors++;
    if (hit !== 1'b0) begin $display("FAIL miss_hit: got %b want 0", hit); miscompares++; end
    lc = low_cnt;
    wr(BASE + 8, 32'h77);
    wr(BASE + 12, 32'h77);
    a = BASE + 4; #1;
    vectors++;
    if (rd !== 32'h4) begin $display("FAIL miss_status: got %h want 00000004", rd); miscompares++; end
    for (int i = 0; i < 60; i++) tick();
    vectors++;
    if (rx_q.size() != 0 || low_cnt != lc) begin $display("FAIL miss_no_frame: got %0d frames/%0d low want 0/0", rx_q.size(), low_cnt - lc); miscompares++; end
  endtask
  task automatic test_reset_mid();
    int lc;
    wr(BASE, 32'h5A);
    wr(BASE, 32'hC3);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    // The first frame's start bit began one edge ago; 17 more edges lands in data bit 3.
    for (int i = 0; i < 17; i++) tick();
    reset = 1;
    #1;
    vectors++;
    if (txd !== 1'b1) begin $display("FAIL midreset_txd: got %b want 1", txd); miscompares++; end
    tick();
    reset = 0;
    exp_q.delete();
    a = BASE + 4; #1;
    vectors++;
    if (rd !== 32'h4) begin $display("FAIL midreset_status: got %h want 00000004", rd); miscompares++; end
    lc = low_cnt;
    for (int i = 0; i < 120; i++) tick();
    vectors++;
    if (rx_q.size() != 0 || low_cnt != lc) begin $display("FAIL midreset_no_frame: got %0d frames/%0d low want 0/0", rx_q.size(), low_cnt - lc); miscompares++; end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_patterns();
    test_back_to_back();
    test_miss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
